// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data bus: word-addressed 32-bit RAM,
// one access at a time with a fixed number of wait states and a ready pulse.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_bus,
    input  logic [31:0] data_bus_out,
    input  logic        mem_read,
    input  logic        mem_wrt,
    output logic [31:0] data_bus_in,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    localparam int         DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic                  enter_done;
    logic                  src_idle;
    logic [29:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_rd;
    logic                  acc_wr;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_oor;
    logic                  acc_both;
    logic                  commit_rd;
    logic                  commit_wr;

    // Byte-lane bits of the address have no meaning for a word RAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_bus[1:0];

    // With zero wait states the commit happens on the capture edge itself,
    // so the access fields come straight from the bus while in IDLE.
    assign src_idle  = (state_q == S_IDLE);
    assign acc_addr  = src_idle ? addr_bus[31:2] : addr_q;
    assign acc_wdata = src_idle ? data_bus_out   : wdata_q;
    assign acc_rd    = src_idle ? mem_read       : rd_q;
    assign acc_wr    = src_idle ? mem_wrt        : wr_q;
    assign acc_idx   = acc_addr[ADDR_WIDTH-1:0];
    assign acc_oor   = |acc_addr[29:ADDR_WIDTH];
    assign acc_both  = acc_rd & acc_wr;
    assign commit_rd = enter_done & acc_rd & ~acc_wr;
    assign commit_wr = enter_done & acc_wr & ~acc_rd & ~acc_oor;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        enter_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_wrt) begin
                    addr_d  = addr_bus[31:2];
                    wdata_d = data_bus_out;
                    rd_d    = mem_read;
                    wr_d    = mem_wrt;
                    cnt_d   = WAIT_LD;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d      = 4'd0;
                    state_d    = S_DONE;
                    enter_done = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        data_d = data_q;
        if (commit_rd) begin
            data_d = acc_oor ? 32'd0 : mem[acc_idx];
        end
        ready_d = enter_done;
        err_d   = enter_done & (acc_oor | acc_both);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Captured address/data need no reset; they are only used after a capture.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && commit_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign data_bus_in = data_q;
    assign mem_ready   = ready_q;
    assign mem_err     = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with zero wait states for back-to-back strobe behaviour.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        rd, wr, ready, err, bsy;
    logic [31:0] addr0, wdata0, rdata0;
    logic        rd0, wr0, ready0, err0, bsy0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .addr_bus(addr), .data_bus_out(wdata),
        .mem_read(rd), .mem_wrt(wr), .data_bus_in(rdata),
        .mem_ready(ready), .mem_err(err), .busy(bsy)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .addr_bus(addr0), .data_bus_out(wdata0),
        .mem_read(rd0), .mem_wrt(wr0), .data_bus_in(rdata0),
        .mem_ready(ready0), .mem_err(err0), .busy(bsy0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one request on the WAIT=2 instance, drops the strobes after the
    // capture edge and leaves the bench in the DONE cycle (or after a timeout).
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic r, input logic w);
        int n;
        addr = a; wdata = d; rd = r; wr = w;
        step();
        rd = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD;
        n = 1;
        while (!ready && n < 12) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
    endtask

    initial begin
        int saw;
        logic [5:0] exp_pat;
        rst = 1'b1;
        addr = 0; wdata = 0; rd = 0; wr = 0;
        addr0 = 0; wdata0 = 0; rd0 = 0; wr0 = 0;
        step(); step();
        rst = 1'b0;
        check("rst_data", rdata, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(bsy), 32'd0);
        check("rst_busy0", 32'(bsy0), 32'd0);

        // Write with two wait states, including the intermediate BUSY cycle.
        addr = 32'h10; wdata = 32'hDEAD_BEEF; wr = 1'b1;
        step();
        wr = 1'b0;
        check("wr_busy_e0", 32'(bsy), 32'd1);
        check("wr_ready_e0", 32'(ready), 32'd0);
        step();
        check("wr_ready_e1", 32'(ready), 32'd0);
        step();
        check("wr_ready_e2", 32'(ready), 32'd1);
        check("wr_err", 32'(err), 32'd0);
        check("wr_busy_done", 32'(bsy), 32'd1);
        step();
        check("wr_ready_drop", 32'(ready), 32'd0);
        check("wr_busy_idle", 32'(bsy), 32'd0);

        access("rd10", 32'h10, 32'h0, 1'b1, 1'b0);
        check("rd10_data", rdata, 32'hDEAD_BEEF);
        check("rd10_err", 32'(err), 32'd0);
        step();
        access("rd13", 32'h13, 32'h0, 1'b1, 1'b0);
        check("rd13_data", rdata, 32'hDEAD_BEEF);
        step();

        access("wr400", 32'h400, 32'h7777_7777, 1'b0, 1'b1);
        check("wr400_ready", 32'(ready), 32'd1);
        check("wr400_err", 32'(err), 32'd1);
        step();
        access("rd400", 32'h400, 32'h0, 1'b1, 1'b0);
        check("rd400_data", rdata, 32'd0);
        check("rd400_err", 32'(err), 32'd1);
        step();
        access("rd0", 32'h0, 32'h0, 1'b1, 1'b0);
        check("rd0_not_aliased", rdata == 32'h7777_7777 ? 32'd1 : 32'd0, 32'd0);
        step();

        // Both strobes: flagged, no RAM change, read data held.
        access("wr20", 32'h20, 32'h5, 1'b0, 1'b1);
        step();
        access("rd10b", 32'h10, 32'h0, 1'b1, 1'b0);
        step();
        access("both20", 32'h20, 32'h999, 1'b1, 1'b1);
        check("both_err", 32'(err), 32'd1);
        check("both_data_held", rdata, 32'hDEAD_BEEF);
        step();
        access("rd20", 32'h20, 32'h0, 1'b1, 1'b0);
        check("rd20_data", rdata, 32'h5);
        step();

        // Reset one edge into BUSY aborts the write.
        access("wr30_old", 32'h30, 32'h1111, 1'b0, 1'b1);
        step();
        addr = 32'h30; wdata = 32'h1234; wr = 1'b1;
        step();
        wr = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ready) saw++;
        end
        check("abort_no_ready", 32'(saw), 32'd0);
        check("abort_busy", 32'(bsy), 32'd0);
        access("rd30", 32'h30, 32'h0, 1'b1, 1'b0);
        check("rd30_old", rdata, 32'h1111);
        step();

        // Zero wait states: capture edge enters DONE directly.
        addr0 = 32'h0; wdata0 = 32'hA5; wr0 = 1'b1;
        step();
        wr0 = 1'b0;
        check("w0_ready", 32'(ready0), 32'd1);
        step();
        check("w0_idle", 32'(bsy0), 32'd0);
        rd0 = 1'b1;
        exp_pat = 6'b010101;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("hold_ready_%0d", i), 32'(ready0), 32'(exp_pat[i]));
            check($sformatf("hold_busy_%0d", i), 32'(bsy0), 32'(exp_pat[i]));
            check($sformatf("hold_data_%0d", i), rdata0, 32'hA5);
        end
        rd0 = 1'b0;
        step();
        check("hold_release", 32'(ready0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
